fetch_prefetch: RTL



---
 rtl/fetch_prefetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: multi-request instruction fetch stage. It keeps up to
// MaxOutstanding reads in flight and queues responses in a Depth-entry
// PC+instruction FIFO. A redirect from MEM flushes the FIFO and discards the
// responses to requests that are still in flight.
module fetch_prefetch #(
  parameter int unsigned     Xlen           = 32,
  parameter int unsigned     Ilen           = 32,
  parameter int unsigned     Depth          = 4,
  parameter int unsigned     MaxOutstanding = 2,
  parameter logic [Xlen-1:0] ResetPc        = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            control_hazard_i,
  input  logic [Xlen-1:0] pc_target_i,
  input  logic            mem_ready_i,
  output logic            mem_valid_o,
  output logic [Xlen-1:0] mem_addr_o,
  input  logic [Xlen-1:0] mem_rdata_i,
  input  logic            mem_rvalid_i,
  input  logic            inst_ready_i,
  output logic            inst_valid_o,
  output logic [Xlen-1:0] inst_pc_o,
  output logic [Ilen-1:0] inst_data_o
);

  localparam int unsigned     PtrW    = $clog2(Depth);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam logic [CntW:0]   DepthC  = (CntW + 1)'(Depth);
  localparam logic [CntW-1:0] MaxOutC = CntW'(MaxOutstanding);
  localparam logic [Xlen-1:0] Step    = Xlen'(4);

  logic [Xlen-1:0] req_pc_q, req_pc_d;
  logic [Xlen-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [Xlen-1:0] fifo_pc_q   [Depth];
  logic [Ilen-1:0] fifo_data_q [Depth];

  logic [CntW:0] credit_used;
  logic          accept;
  logic          push;
  logic          pop;

  // Issue, response and output handshakes. Stale in-flight requests still
  // hold credit, so count + outstanding bounds the FIFO occupancy.
  always_comb begin
    credit_used  = {1'b0, count_q} + {1'b0, out_q};
    mem_valid_o  = !rst_i && !control_hazard_i && (out_q < MaxOutC) && (credit_used < DepthC);
    mem_addr_o   = req_pc_q;
    accept       = mem_valid_o && mem_ready_i;
    push         = mem_rvalid_i && !control_hazard_i && (drop_q == '0);
    inst_valid_o = !rst_i && (count_q != '0);
    pop          = inst_valid_o && inst_ready_i;
    inst_pc_o    = fifo_pc_q[rd_ptr_q];
    inst_data_o  = fifo_data_q[rd_ptr_q];
  end

  // Next-state for PCs, in-flight/drop counters and FIFO bookkeeping.
  always_comb begin
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (control_hazard_i) begin
      // No accept can happen here, so every in-flight request not answered
      // this cycle becomes stale.
      req_pc_d  = pc_target_i;
      resp_pc_d = pc_target_i;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      drop_d    = out_q - CntW'(mem_rvalid_i);
      out_d     = out_q - CntW'(mem_rvalid_i);
    end else begin
      if (accept) begin
        req_pc_d = req_pc_q + Step;
      end
      case ({accept, mem_rvalid_i})
        2'b10:   out_d = out_q + CntW'(1);
        2'b01:   out_d = out_q - CntW'(1);
        default: out_d = out_q;
      endcase
      if (mem_rvalid_i && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + Step;
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q  <= ResetPc;
      resp_pc_q <= ResetPc;
      out_q     <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_data_q[wr_ptr_q] <= mem_rdata_i[Ilen-1:0];
    end
  end

  a_rvalid_with_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> (out_q != '0));

  a_target_aligned: assert property (
    @(posedge clk_i) disable iff (rst_i) control_hazard_i |-> (pc_target_i[1:0] == 2'b00));

endmodule
